// File: rtl/hex_word_tx_sequencer.sv
// -----------------------------------------------------------------------------
// hex_word_tx_sequencer
//
// Prints a parallel word as ASCII hex on a UART. The block walks the word
// one nibble at a time, most significant nibble first. Each nibble goes
// through an external nibble-to-ASCII converter. The resulting byte is handed
// to the UART TX with a start/busy handshake. When APPEND_CRLF is set, CR and
// then LF follow the last digit.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   word_valid  source has a word on word_data
//   word_ready  high only while idle; a word is taken when valid & ready
//   word_data   word to print (4*NIBBLES bits)
//   hex_nibble  nibble presented to the converter (top of the shift register)
//   ascii_in    converter output, combinational from hex_nibble
//   tx_data     registered byte for the UART TX
//   tx_start    one-cycle start pulse for the UART TX
//   tx_busy     UART TX busy
//   busy        high from word acceptance until the last byte's tx_busy falls
// -----------------------------------------------------------------------------
module hex_word_tx_sequencer #(
    parameter int NIBBLES     = 4,
    parameter int APPEND_CRLF = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic [4*NIBBLES-1:0] word_data,
    output logic [3:0]           hex_nibble,
    input  logic [7:0]           ascii_in,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int TOTAL = NIBBLES + 2 * APPEND_CRLF;
    // The index has to reach NIBBLES+2, so it must hold at least NIBBLES+3 values.
    localparam int IDX_W = $clog2(NIBBLES + 3);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   idx_inc;
    logic [7:0]         sel_byte;

    assign idx_inc = idx_q + 1'b1;

    // The current digit comes from the converter. After the digits, the
    // index selects CR and then LF.
    always_comb begin
        sel_byte = 8'h0A;
        if (idx_q < IDX_W'(NIBBLES)) begin
            sel_byte = ascii_in;
        end else if (idx_q == IDX_W'(NIBBLES)) begin
            sel_byte = 8'h0D;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;

        unique case (state_q)
            IDLE: begin
                if (word_valid) begin
                    shift_d = word_data;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Hold off while the TX is still busy, including a busy that
                // was already high when the state was entered.
                if (!tx_busy) begin
                    tx_data_d  = sel_byte;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    idx_d   = idx_inc;
                    shift_d = shift_q << 4;
                    if (idx_inc < IDX_W'(TOTAL)) begin
                        state_d = SEND;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        word_ready = (state_q == IDLE);
        hex_nibble = shift_q[W-1 -: 4];
        tx_data    = tx_data_q;
        tx_start   = tx_start_q;
        busy       = busy_q;
    end

endmodule

// File: tb/tb_hex_word_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hex_word_tx_sequencer
//
// Bench for hex_word_tx_sequencer. One instance appends CR LF. A second
// instance sends the digits only. Each instance has a UART TX model that
// raises busy one cycle after tx_start and holds it for 10 cycles. A monitor
// records every byte that is sent.
// -----------------------------------------------------------------------------
module tb_hex_word_tx_sequencer;

    logic        clk;
    logic        rst;

    // instance A: NIBBLES=4, APPEND_CRLF=1
    logic        word_valid, word_ready;
    logic [15:0] word_data;
    logic [3:0]  hex_nibble;
    logic [7:0]  ascii_in;
    logic [7:0]  tx_data;
    logic        tx_start, tx_busy, busy;

    // instance B: NIBBLES=4, APPEND_CRLF=0
    logic        word_valid_b, word_ready_b;
    logic [15:0] word_data_b;
    logic [3:0]  hex_nibble_b;
    logic [7:0]  ascii_in_b;
    logic [7:0]  tx_data_b;
    logic        tx_start_b, tx_busy_b, busy_b;

    int checks = 0;
    int errors = 0;

    hex_word_tx_sequencer #(.NIBBLES(4), .APPEND_CRLF(1)) dut (
        .clk(clk), .rst(rst),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .hex_nibble(hex_nibble), .ascii_in(ascii_in),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy)
    );

    hex_word_tx_sequencer #(.NIBBLES(4), .APPEND_CRLF(0)) dut_b (
        .clk(clk), .rst(rst),
        .word_valid(word_valid_b), .word_ready(word_ready_b), .word_data(word_data_b),
        .hex_nibble(hex_nibble_b), .ascii_in(ascii_in_b),
        .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_busy(tx_busy_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nibble-to-ASCII converter
    function automatic logic [7:0] hex2asc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
    assign ascii_in   = hex2asc(hex_nibble);
    assign ascii_in_b = hex2asc(hex_nibble_b);

    // UART TX models
    logic       pend, pend_b;
    int         hold, hold_b;
    logic       force_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0; hold <= 0;
        end else if (tx_start) begin
            pend <= 1'b1;
        end else if (pend) begin
            pend <= 1'b0; hold <= 10;
        end else if (hold > 0) begin
            hold <= hold - 1;
        end
    end
    assign tx_busy = force_busy | (hold != 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_b <= 1'b0; hold_b <= 0;
        end else if (tx_start_b) begin
            pend_b <= 1'b1;
        end else if (pend_b) begin
            pend_b <= 1'b0; hold_b <= 10;
        end else if (hold_b > 0) begin
            hold_b <= hold_b - 1;
        end
    end
    assign tx_busy_b = (hold_b != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte monitors. tx_start must never be high for two cycles in a row.
    logic [7:0] byte_q[$];
    logic [7:0] byte_q_b[$];
    logic       prev_start;

    always @(posedge clk) begin
        if (tx_start) begin
            byte_q.push_back(tx_data);
            chk("start_single_cycle", {31'd0, prev_start}, 32'd0);
        end
        prev_start = tx_start;
        if (tx_start_b) byte_q_b.push_back(tx_data_b);
    end

    typedef struct {
        logic [15:0] word;
        int          n;
        logic [7:0]  exp [6];
    } vec_t;

    vec_t vecs[3];

    task automatic send_word(input logic [15:0] w);
        int n = 0;
        @(negedge clk);
        while (!word_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("send_ready_timeout", 32'd0, 32'd1);
        word_valid = 1'b1;
        word_data  = w;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        chk("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(word_ready && !busy) && n < 2000);
        if (n >= 2000) chk({name, "_idle_timeout"}, 32'd0, 32'd1);
        // idle must only come back after the final tx_busy has fallen
        chk({name, "_txbusy_at_idle"}, {31'd0, tx_busy}, 32'd0);
    endtask

    task automatic check_bytes(input string name, input logic [7:0] q[$],
                               input logic [7:0] exp[6], input int n);
        chk({name, "_count"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), {24'd0, q[i]}, {24'd0, exp[i]});
    endtask

    initial begin
        logic [7:0] e6[6];
        logic [7:0] e12[12];
        int n;
        int idle_seen;

        vecs[0] = '{16'h1A2F, 6, '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A}};
        vecs[1] = '{16'h1234, 6, '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}};
        vecs[2] = '{16'h00F1, 6, '{8'h30, 8'h30, 8'h46, 8'h31, 8'h0D, 8'h0A}};

        rst = 1'b1;
        force_busy = 1'b0;
        prev_start = 1'b0;
        word_valid = 1'b1;
        word_data = 16'h1234;
        word_valid_b = 1'b0;
        word_data_b = 16'h0;

        // Reset state, with word_valid high but not captured
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_word_ready", {31'd0, word_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_hex_nibble", {28'd0, hex_nibble}, 32'd0);
        word_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Table-driven words
        for (int v = 0; v < 3; v++) begin
            byte_q.delete();
            send_word(vecs[v].word);
            wait_idle($sformatf("vec%0d", v));
            check_bytes($sformatf("vec%0d", v), byte_q, vecs[v].exp, vecs[v].n);
            $display("vector %0d word 0x%04h: %0d bytes", v, vecs[v].word, byte_q.size());
        end

        // No CR LF: 0x0000 -> four '0'
        byte_q_b.delete();
        @(negedge clk);
        word_valid_b = 1'b1;
        word_data_b = 16'h0000;
        @(posedge clk);
        #1;
        word_valid_b = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(word_ready_b && !busy_b) && n < 2000);
        if (n >= 2000) chk("nocrlf_idle_timeout", 32'd0, 32'd1);
        chk("nocrlf_txbusy_at_idle", {31'd0, tx_busy_b}, 32'd0);
        e6 = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h00, 8'h00};
        check_bytes("nocrlf", byte_q_b, e6, 4);
        $display("no-crlf word 0x0000: %0d bytes", byte_q_b.size());

        // tx_busy high before and during acceptance of 0xBEEF
        byte_q.delete();
        @(negedge clk);
        force_busy = 1'b1;
        send_word(16'hBEEF);
        repeat (6) begin
            @(negedge clk);
            chk("beef_no_start_while_busy", {31'd0, tx_start}, 32'd0);
        end
        force_busy = 1'b0;
        @(negedge clk);
        chk("beef_first_start", {31'd0, tx_start}, 32'd1);
        chk("beef_first_data", {24'd0, tx_data}, 32'h42);
        wait_idle("beef");
        e6 = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        check_bytes("beef", byte_q, e6, 6);
        $display("busy-held word 0xBEEF: %0d bytes", byte_q.size());

        // word_valid while busy is ignored
        byte_q.delete();
        send_word(16'h1234);
        repeat (20) @(negedge clk);
        word_valid = 1'b1;
        word_data = 16'h5555;
        @(negedge clk);
        word_valid = 1'b0;
        wait_idle("ignore");
        e6 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        check_bytes("ignore", byte_q, e6, 6);
        $display("ignored-valid word 0x1234: %0d bytes", byte_q.size());

        // Asynchronous reset after the second byte of 0xABCD
        byte_q.delete();
        send_word(16'hABCD);
        n = 0;
        while (byte_q.size() < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("abcd_two_bytes_timeout", 32'd0, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_word_ready", {31'd0, word_ready}, 32'd1);
        chk("midrst_hex_nibble", {28'd0, hex_nibble}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst_abandoned_count", byte_q.size(), 32'd2);
        $display("reset mid-word 0xABCD: %0d bytes before reset", byte_q.size());
        byte_q.delete();
        send_word(16'h00F1);
        wait_idle("after_rst");
        check_bytes("after_rst", byte_q, vecs[2].exp, 6);
        $display("after-reset word 0x00F1: %0d bytes", byte_q.size());

        // Held word_valid: 0x0009 then 0xFFFF
        byte_q.delete();
        @(negedge clk);
        word_valid = 1'b1;
        word_data = 16'h0009;
        @(posedge clk);
        #1;
        chk("b2b_first_accept", {31'd0, busy}, 32'd1);
        word_data = 16'hFFFF;
        idle_seen = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!word_ready && n < 2000);
        if (n >= 2000) chk("b2b_gap_timeout", 32'd0, 32'd1);
        if (word_ready) idle_seen++;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        chk("b2b_idle_gap", {31'd0, idle_seen >= 1}, 32'd1);
        chk("b2b_second_accept", {31'd0, busy}, 32'd1);
        wait_idle("b2b");
        e12 = '{8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A,
                8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
        chk("b2b_count", byte_q.size(), 32'd12);
        for (int i = 0; i < 12 && i < byte_q.size(); i++)
            chk($sformatf("b2b_byte%0d", i), {24'd0, byte_q[i]}, {24'd0, e12[i]});
        $display("back-to-back words 0x0009,0xFFFF: %0d bytes", byte_q.size());

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_word_tx_sequencer.md
Name: hex_word_tx_sequencer

Overview:
- Sits between a data source and the UART transmitter.
- Accepts a parallel word and walks it one nibble at a time, most-significant nibble first, through the existing nibble-to-ASCII converter.
- Hands each resulting ASCII byte to the UART TX with a start/busy handshake, then optionally appends CR LF.
- Turns any internal value into a human-readable hex line on the serial port.

Parameters:
- NIBBLES, 4: number of hex digits per word; word width = 4*NIBBLES; legal range 1..8.
- APPEND_CRLF, 1: 1 = send 0x0D then 0x0A after the last digit; 0 = digits only.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- word_valid  in  1  source has a word on word_data.
- word_ready  out  1  high only in IDLE; a word is accepted on a clk edge where word_valid and word_ready are both high.
- word_data  in  4*NIBBLES  word to print.
- hex_nibble  out  4  nibble presented to the converter; the top 4 bits of the internal shift register.
- ascii_in  in  8  converter output, combinational from hex_nibble.
- tx_data  out  8  byte to UART TX; registered; stable from the tx_start pulse until the next load.
- tx_start  out  1  one-cycle start pulse to UART TX.
- tx_busy  in  1  UART TX busy; TX raises it within a bounded number of cycles after tx_start and drops it when the frame is done.
- busy  out  1  high from word acceptance until the final byte's tx_busy falls.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, shift register=0, char index=0.
  - tx_start=0, tx_data=0x00, busy=0, hex_nibble=0x0.
  - word_ready reads 1 (decoded from IDLE), but no word is captured while rst is high.
- States: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - word_ready=1.
  - On accept: shift register <= word_data, idx <= 0, busy <= 1, go to SEND.
- SEND:
  - If tx_busy=1, hold in SEND.
  - Else load tx_data with the selected byte, pulse tx_start for exactly one cycle, go to WAIT_HI.
  - Byte selection: idx < NIBBLES gives ascii_in; idx == NIBBLES gives 0x0D; idx == NIBBLES+1 gives 0x0A.
- WAIT_HI:
  - tx_start=0.
  - Stay until tx_busy=1, then go to WAIT_LO.
  - No timeout; TX is required to acknowledge.
- WAIT_LO:
  - Stay until tx_busy=0.
  - Then idx <= idx+1 and shift register <= shift register << 4 (zero fill).
  - If idx+1 < total (total = NIBBLES + 2*APPEND_CRLF), go to SEND.
  - Else busy <= 0 and go to IDLE.
- Latency: accept at edge N; earliest tx_start is high in cycle N+1 (SEND with tx_busy low). Per byte: 1 SEND cycle + WAIT_HI + WAIT_LO durations.
- Back-to-back words: IDLE is re-entered for at least one cycle between words. A held word_valid is accepted on the first IDLE edge, so the minimum gap between words is one cycle.
- word_valid outside IDLE is ignored; word_data is not sampled.
- tx_busy already high on entry to SEND: no pulse is issued until it falls.
- Reset mid-word: all outputs return to their reset values immediately. The partially sent word is abandoned with no CR LF. The next accepted word restarts from its MS nibble.
- Widths: idx is wide enough for NIBBLES+2. The shift register is exactly 4*NIBBLES bits. No arithmetic on data; hex_nibble is a pure slice.

Test Plan:
- NIBBLES=4, CRLF=1; word 0x1A2F; TX model raises busy 1 cycle after start and holds it 10 cycles -> exactly 6 tx_start pulses with tx_data 0x31,0x41,0x32,0x46,0x0D,0x0A in order; busy falls and word_ready rises after the last tx_busy fall.
- APPEND_CRLF=0, word 0x0000 -> four pulses, all tx_data=0x30, no 0x0D/0x0A; IDLE reached after the fourth tx_busy fall.
- tx_busy held high before and during accept of 0xBEEF -> tx_start stays 0 while busy is high; first pulse with 0x42 occurs the cycle after tx_busy drops.
- word_valid pulsed with 0x5555 while busy on 0x1234 -> 0x5555 is never sent; output is 0x31,0x32,0x33,0x34,CR,LF only.
- rst asserted asynchronously after the second byte of 0xABCD -> tx_start=0, tx_data=0x00, busy=0 immediately; after release word 0x00F1 produces 0x30,0x30,0x46,0x31,CR,LF.
- word_valid held high with words 0x0009 then 0xFFFF -> 12 bytes in order (0x30,0x30,0x30,0x39,CR,LF,0x46 x4,CR,LF); at least one word_ready-high IDLE cycle between words.
